// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants for the UART receive byte FIFO: default data width, depth and pointer sizing.
// The optional drop counter (UART_RX_FIFO_OVF_CNT_EN) uses the saturating increment below.
package uart_rx_fifo_pkg;

    localparam int N_DATA_DEF     = 8;
    localparam int FIFO_DEPTH_DEF = 16;
    localparam int NB_ADDR_DEF    = 4;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// FIFO storage: FIFO_DEPTH x N_DATA register array, one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
module uart_rx_fifo_mem
    import uart_rx_fifo_pkg::*;
#(
    parameter int N_DATA     = N_DATA_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int NB_ADDR    = NB_ADDR_DEF
) (
    input  logic               clk,
    input  logic               we,
    input  logic [NB_ADDR-1:0] waddr,
    input  logic [N_DATA-1:0]  wdata,
    input  logic [NB_ADDR-1:0] raddr,
    output logic [N_DATA-1:0]  rdata
);

    logic [N_DATA-1:0] mem [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO between uart_rx and the command interface, with sticky
// overflow flag. Define UART_RX_FIFO_OVF_CNT_EN to add the saturating o_ovf_count output.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int N_DATA     = N_DATA_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int NB_ADDR    = NB_ADDR_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [N_DATA-1:0]  i_push_data,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic               i_clr_ovf,
    output logic [N_DATA-1:0]  o_data,
    output logic               o_valid,
    output logic               o_empty,
    output logic               o_full,
    output logic [NB_ADDR:0]   o_count,
`ifdef UART_RX_FIFO_OVF_CNT_EN
    output logic [7:0]         o_ovf_count,
`endif
    output logic               o_overflow
);

    logic [NB_ADDR:0]  wr_ptr;
    logic [NB_ADDR:0]  rd_ptr;
    logic [N_DATA-1:0] rd_data;
    logic              pop_eff;
    logic              push_ok;
    logic              drop;

    // Flags come only from registered pointers, so push has no combinational path to outputs.
    assign o_empty = (wr_ptr == rd_ptr);
    assign o_full  = (wr_ptr[NB_ADDR] != rd_ptr[NB_ADDR]) &&
                     (wr_ptr[NB_ADDR-1:0] == rd_ptr[NB_ADDR-1:0]);
    assign o_valid = !o_empty;
    assign o_count = wr_ptr - rd_ptr;
    assign o_data  = o_empty ? '0 : rd_data;

    assign pop_eff = i_pop && o_valid;
    assign push_ok = i_push && (!o_full || pop_eff);
    assign drop    = i_push && o_full && !pop_eff;

    uart_rx_fifo_mem #(
        .N_DATA     (N_DATA),
        .FIFO_DEPTH (FIFO_DEPTH),
        .NB_ADDR    (NB_ADDR)
    ) u_mem (
        .clk   (i_clk),
        .we    (push_ok),
        .waddr (wr_ptr[NB_ADDR-1:0]),
        .wdata (i_push_data),
        .raddr (rd_ptr[NB_ADDR-1:0]),
        .rdata (rd_data)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_eff) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            o_overflow <= 1'b0;
        end else if (drop) begin
            o_overflow <= 1'b1;
        end else if (i_clr_ovf) begin
            o_overflow <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_OVF_CNT_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            o_ovf_count <= 8'd0;
        end else if (i_clr_ovf) begin
            o_ovf_count <= drop ? 8'd1 : 8'd0;
        end else if (drop) begin
            o_ovf_count <= sat_inc8(o_ovf_count);
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: a queue model tracks accepted bytes and overflow state,
// and every pop compares the DUT head byte against the model head.
module tb_uart_rx_fifo;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic [7:0] i_push_data = 8'h00;
    logic       i_push = 1'b0;
    logic       i_pop = 1'b0;
    logic       i_clr_ovf = 1'b0;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_empty;
    logic       o_full;
    logic [4:0] o_count;
    logic       o_overflow;
`ifdef UART_RX_FIFO_OVF_CNT_EN
    logic [7:0] o_ovf_count;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0] q[$];
    logic       exp_ovf = 1'b0;
    logic [7:0] exp_cnt = 8'd0;
    logic [7:0] exp_head;
    logic [7:0] got_head;
    logic       did_pop;
    logic [7:0] dval = 8'h00;

    uart_rx_fifo dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push_data (i_push_data),
        .i_push      (i_push),
        .i_pop       (i_pop),
        .i_clr_ovf   (i_clr_ovf),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_empty     (o_empty),
        .o_full      (o_full),
        .o_count     (o_count),
`ifdef UART_RX_FIFO_OVF_CNT_EN
        .o_ovf_count (o_ovf_count),
`endif
        .o_overflow  (o_overflow)
    );

    always #5 i_clk = ~i_clk;

    // Applies one cycle of stimulus, advances the model, captures the head byte seen on a pop.
    task automatic cycle(input logic push, input logic [7:0] d, input logic pop, input logic clr);
        logic full_m;
        logic peff_m;
        logic drop_m;
        i_push = push; i_push_data = d; i_pop = pop; i_clr_ovf = clr;
        full_m = (q.size() == 16);
        peff_m = pop && (q.size() > 0);
        drop_m = push && full_m && !peff_m;
        did_pop = peff_m;
        if (peff_m) begin
            got_head = o_data;
            exp_head = q.pop_front();
        end
        if (push && !drop_m) q.push_back(d);
        if (drop_m) begin
            exp_ovf = 1'b1;
            exp_cnt = clr ? 8'd1 : ((exp_cnt == 8'hFF) ? exp_cnt : exp_cnt + 8'd1);
        end else if (clr) begin
            exp_ovf = 1'b0;
            exp_cnt = 8'd0;
        end
        @(posedge i_clk); #1;
        i_push = 1'b0; i_pop = 1'b0; i_clr_ovf = 1'b0;
    endtask

    task automatic model_reset();
        q.delete();
        exp_ovf = 1'b0;
        exp_cnt = 8'd0;
    endtask

    task automatic test_reset();
        i_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i_push = 1'b1; i_push_data = 8'hE0 + 8'(i);
            @(posedge i_clk); #1;
        end
        i_push = 1'b0;
        model_reset();
        total++; if (o_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%0b exp=1", o_empty); end
        total++; if (o_count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", o_count); end
        total++; if (o_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%0h exp=0", o_data); end
        total++; if (o_overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b exp=0", o_overflow); end
        total++; if ({o_valid, o_full} !== 2'b00) begin bad++; $display("FAIL reset_valid_full got=%0b exp=00", {o_valid, o_full}); end
        i_rst = 1'b1;
        @(posedge i_clk); #1;
    endtask

    task automatic test_order();
        logic [7:0] pat [3];
        pat[0] = 8'hA5; pat[1] = 8'h3C; pat[2] = 8'h0F;
        for (int i = 0; i < 3; i++) cycle(1'b1, pat[i], 1'b0, 1'b0);
        total++; if (o_data !== 8'hA5 || o_valid !== 1'b1) begin bad++; $display("FAIL order_fwft got=%0h/%0b exp=a5/1", o_data, o_valid); end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            total++; if (!did_pop || got_head !== pat[i]) begin bad++; $display("FAIL order_pop%0d got=%0h exp=%0h", i, got_head, pat[i]); end
        end
        total++; if (o_empty !== 1'b1 || o_count !== 5'd0) begin bad++; $display("FAIL order_empty got=%0b/%0d exp=1/0", o_empty, o_count); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 17; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        total++; if (o_full !== 1'b1) begin bad++; $display("FAIL ovf_full got=%0b exp=1", o_full); end
        total++; if (o_count !== 5'd16) begin bad++; $display("FAIL ovf_count got=%0d exp=16", o_count); end
        total++; if (o_overflow !== exp_ovf || exp_ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0b exp=1", o_overflow); end
`ifdef UART_RX_FIFO_OVF_CNT_EN
        total++; if (o_ovf_count !== 8'd1) begin bad++; $display("FAIL ovf_cnt got=%0d exp=1", o_ovf_count); end
`endif
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            total++; if (got_head !== 8'(i)) begin bad++; $display("FAIL ovf_pop%0d got=%0h exp=%0h", i, got_head, 8'(i)); end
        end
        total++; if (o_empty !== 1'b1 || o_overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0b/%0b exp=1/1", o_empty, o_overflow); end
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        total++; if (o_overflow !== exp_ovf) begin bad++; $display("FAIL ovf_clear got=%0b exp=%0b", o_overflow, exp_ovf); end
    endtask

    task automatic test_full_pushpop();
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
        cycle(1'b1, 8'h77, 1'b1, 1'b0);
        total++; if (got_head !== 8'h40) begin bad++; $display("FAIL fpp_head got=%0h exp=40", got_head); end
        total++; if (o_overflow !== 1'b0) begin bad++; $display("FAIL fpp_ovf got=%0b exp=0", o_overflow); end
        total++; if (o_count !== 5'd16 || o_full !== 1'b1) begin bad++; $display("FAIL fpp_count got=%0d/%0b exp=16/1", o_count, o_full); end
        // set wins over a coincident clear
        cycle(1'b1, 8'h99, 1'b0, 1'b1);
        total++; if (o_overflow !== 1'b1) begin bad++; $display("FAIL fpp_setwins got=%0b exp=1", o_overflow); end
`ifdef UART_RX_FIFO_OVF_CNT_EN
        total++; if (o_ovf_count !== exp_cnt) begin bad++; $display("FAIL fpp_cnt got=%0d exp=%0d", o_ovf_count, exp_cnt); end
`endif
        while (q.size() > 0) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            total++; if (got_head !== exp_head) begin bad++; $display("FAIL fpp_drain got=%0h exp=%0h", got_head, exp_head); end
        end
        total++; if (exp_head !== 8'h77) begin bad++; $display("FAIL fpp_last got=%0h exp=77", exp_head); end
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_empty_pushpop();
        cycle(1'b1, 8'h5A, 1'b1, 1'b0);
        total++; if (did_pop !== 1'b0) begin bad++; $display("FAIL epp_model got=%0b exp=0", did_pop); end
        total++; if (o_count !== 5'd1 || o_data !== 8'h5A) begin bad++; $display("FAIL epp_state got=%0d/%0h exp=1/5a", o_count, o_data); end
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        total++; if (got_head !== 8'h5A) begin bad++; $display("FAIL epp_pop got=%0h exp=5a", got_head); end
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        total++; if (o_empty !== 1'b1 || o_count !== 5'd0 || o_data !== 8'h00 || o_overflow !== 1'b0)
        begin bad++; $display("FAIL epp_emptypop got=%0b/%0d/%0h/%0b exp=1/0/0/0", o_empty, o_count, o_data, o_overflow); end
    endtask

    task automatic test_wrap();
        int target;
        for (int i = 0; i < 40; i++) begin
            target = 1 + ((i * 7) % 16);
            while (q.size() < target) begin
                cycle(1'b1, dval, 1'b0, 1'b0);
                dval = dval + 8'd1;
            end
            total++; if (o_count !== 5'(q.size())) begin bad++; $display("FAIL wrap_count%0d got=%0d exp=%0d", i, o_count, q.size()); end
            if (i % 2 == 1) begin
                cycle(1'b1, dval, 1'b1, 1'b0);
                dval = dval + 8'd1;
                total++; if (got_head !== exp_head) begin bad++; $display("FAIL wrap_pp%0d got=%0h exp=%0h", i, got_head, exp_head); end
            end
            while (q.size() > target / 2) begin
                cycle(1'b0, 8'h00, 1'b1, 1'b0);
                total++; if (got_head !== exp_head) begin bad++; $display("FAIL wrap_pop%0d got=%0h exp=%0h", i, got_head, exp_head); end
            end
        end
        while (q.size() > 0) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            total++; if (got_head !== exp_head) begin bad++; $display("FAIL wrap_drain got=%0h exp=%0h", got_head, exp_head); end
        end
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
        total++; if (o_count !== 5'd5) begin bad++; $display("FAIL wrap_pre_rst got=%0d exp=5", o_count); end
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        model_reset();
        total++; if (o_empty !== 1'b1 || o_count !== 5'd0 || o_data !== 8'h00) begin bad++; $display("FAIL wrap_rst got=%0b/%0d/%0h exp=1/0/0", o_empty, o_count, o_data); end
    endtask

    initial begin
        test_reset();
        test_order();
        test_overflow();
        test_full_pushpop();
        test_empty_pushpop();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
